// File: rtl/rc4_encrypt_core.sv
// RC4 encryptor: fills external S RAM, runs KSA with a 24-bit key, then XORs PRGA keystream onto the plaintext.
// Latency: 256 INIT + 1536 KSA cycles, then at least 10 cycles per byte (P_RDI..P_PUTCT).
// Backpressure: stalls in P_GETPT while pt_valid=0 and in P_PUTCT while ct_ready=0; no S RAM traffic while stalled.
module rc4_encrypt_core #(
    parameter int MSG_LEN   = 32,
    parameter int KEY_BYTES = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [23:0] secret_key,
    output logic [7:0]  s_address,
    output logic [7:0]  s_data,
    output logic        s_wren,
    input  logic [7:0]  s_q,
    input  logic [7:0]  pt_data,
    input  logic        pt_valid,
    output logic        pt_ready,
    output logic [7:0]  ct_data,
    output logic        ct_valid,
    input  logic        ct_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [4:0] {
        IDLE, INIT,
        K_RDI, K_W1, K_RDJ, K_W2, K_WRI, K_WRJ,
        P_RDI, P_W1, P_RDJ, P_W2, P_WRI, P_WRJ, P_RDK, P_W3, P_GETPT, P_PUTCT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  i_q, i_d, j_q, j_d;
    logic [7:0]  si_q, si_d, sj_q, sj_d, k_q, k_d;
    logic [7:0]  addr_q, addr_d, wdat_q, wdat_d, ct_q, ct_d;
    logic        wren_q, wren_d;
    logic        k_ld_q, k_ld_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [1:0]  kidx_q, kidx_d;
    logic [23:0] key_q, key_d;
    logic [7:0]  key_byte;
    logic [7:0]  k_cur;
    logic [7:0]  j_new;

    // Key byte for the current KSA index; kidx tracks i mod KEY_BYTES, MSB byte first.
    always_comb begin
        key_byte = key_q[23:16];
        for (int n = 0; n < KEY_BYTES; n++) begin
            if (kidx_q == 2'(n)) key_byte = key_q[23-8*n -: 8];
        end
    end

    // Keystream byte arrives on s_q in the first P_GETPT cycle and is held in k_q after that.
    assign k_cur = k_ld_q ? s_q : k_q;

    // Next-state and datapath: every S RAM access is registered one cycle before the RAM sees it.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        k_d     = k_q;
        k_ld_d  = k_ld_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        wren_d  = 1'b0;
        ct_d    = ct_q;
        cnt_d   = cnt_q;
        kidx_d  = kidx_q;
        key_d   = key_q;
        j_new   = 8'd0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = secret_key;
                    i_d     = 8'd0;
                    state_d = INIT;
                end
            end
            INIT: begin
                addr_d = i_q;
                wdat_d = i_q;
                wren_d = 1'b1;
                i_d    = i_q + 8'd1;
                if (i_q == 8'd255) begin
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    kidx_d  = 2'd0;
                    state_d = K_RDI;
                end
            end
            K_RDI: begin
                addr_d  = i_q;
                state_d = K_W1;
            end
            K_W1: state_d = K_RDJ;
            K_RDJ: begin
                si_d    = s_q;
                j_new   = j_q + s_q + key_byte;
                j_d     = j_new;
                addr_d  = j_new;
                state_d = K_W2;
            end
            K_W2: state_d = K_WRI;
            K_WRI: begin
                sj_d    = s_q;
                addr_d  = i_q;
                wdat_d  = s_q;
                wren_d  = 1'b1;
                state_d = K_WRJ;
            end
            K_WRJ: begin
                addr_d = j_q;
                wdat_d = si_q;
                wren_d = 1'b1;
                if (i_q == 8'd255) begin
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    cnt_d   = 9'd0;
                    state_d = P_RDI;
                end else begin
                    i_d     = i_q + 8'd1;
                    kidx_d  = (kidx_q == 2'(KEY_BYTES - 1)) ? 2'd0 : kidx_q + 2'd1;
                    state_d = K_RDI;
                end
            end
            P_RDI: begin
                i_d     = i_q + 8'd1;
                addr_d  = i_q + 8'd1;
                state_d = P_W1;
            end
            P_W1: state_d = P_RDJ;
            P_RDJ: begin
                si_d    = s_q;
                j_new   = j_q + s_q;
                j_d     = j_new;
                addr_d  = j_new;
                state_d = P_W2;
            end
            P_W2: state_d = P_WRI;
            P_WRI: begin
                sj_d    = s_q;
                addr_d  = i_q;
                wdat_d  = s_q;
                wren_d  = 1'b1;
                state_d = P_WRJ;
            end
            P_WRJ: begin
                addr_d  = j_q;
                wdat_d  = si_q;
                wren_d  = 1'b1;
                state_d = P_RDK;
            end
            P_RDK: begin
                addr_d  = si_q + sj_q;
                state_d = P_W3;
            end
            P_W3: begin
                k_ld_d  = 1'b1;
                state_d = P_GETPT;
            end
            P_GETPT: begin
                k_ld_d = 1'b0;
                if (k_ld_q) k_d = s_q;
                if (pt_valid) begin
                    ct_d    = k_cur ^ pt_data;
                    state_d = P_PUTCT;
                end
            end
            P_PUTCT: begin
                if (ct_ready) begin
                    cnt_d   = cnt_q + 9'd1;
                    state_d = (cnt_q + 9'd1 == 9'(MSG_LEN)) ? DONE : P_RDI;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; synchronous active-low reset leaves S RAM contents alone.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            si_q    <= 8'd0;
            sj_q    <= 8'd0;
            k_q     <= 8'd0;
            k_ld_q  <= 1'b0;
            addr_q  <= 8'd0;
            wdat_q  <= 8'd0;
            wren_q  <= 1'b0;
            ct_q    <= 8'd0;
            cnt_q   <= 9'd0;
            kidx_q  <= 2'd0;
            key_q   <= 24'd0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            k_q     <= k_d;
            k_ld_q  <= k_ld_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            wren_q  <= wren_d;
            ct_q    <= ct_d;
            cnt_q   <= cnt_d;
            kidx_q  <= kidx_d;
            key_q   <= key_d;
        end
    end

    assign s_address = addr_q;
    assign s_data    = wdat_q;
    assign s_wren    = wren_q;
    assign ct_data   = ct_q;
    assign pt_ready  = (state_q == P_GETPT);
    assign ct_valid  = (state_q == P_PUTCT);
    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_rc4_encrypt_core.sv
// Bench for rc4_encrypt_core: behavioural S RAM plus a plain-arithmetic RC4 reference.
// Latency: checks the start-to-first-pt_ready distance and the 10-cycle byte cadence.
// Backpressure: exercises ct_ready stalls, pt_valid gaps, mid-run resets and ignored starts.
module tb_rc4_encrypt_core;
    localparam int MSG_LEN = 32;
    localparam int LIMIT   = 8000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] secret_key = 24'd0;
    logic [7:0]  s_address, s_data;
    logic        s_wren;
    logic [7:0]  s_q = 8'd0;
    logic [7:0]  pt_data = 8'd0;
    logic        pt_valid = 1'b0;
    logic        pt_ready;
    logic [7:0]  ct_data;
    logic        ct_valid;
    logic        ct_ready = 1'b0;
    logic        busy, done;

    always #5 clk = ~clk;

    rc4_encrypt_core #(.MSG_LEN(MSG_LEN), .KEY_BYTES(3)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .secret_key(secret_key),
        .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
        .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready),
        .ct_data(ct_data), .ct_valid(ct_valid), .ct_ready(ct_ready),
        .busy(busy), .done(done)
    );

    // Synchronous single-port S RAM with registered address.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (s_wren) mem[s_address] <= s_data;
        s_q <= mem[s_address];
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] ks_ref [256];
    logic [7:0] s_ref  [256];
    logic [7:0] pt_buf [256];
    logic [7:0] ct_buf [256];
    logic [7:0] keep_a [256];
    int first_rdy, bad_gap;

    // Textbook RC4: KSA then PRGA with integer arithmetic.
    task automatic rc4_ref(input logic [23:0] key);
        int s [256];
        int i, j, t;
        logic [23:0] kk;
        for (int n = 0; n < 256; n++) s[n] = n;
        j = 0;
        for (int n = 0; n < 256; n++) begin
            kk = key >> (8 * (2 - (n % 3)));
            j = (j + s[n] + int'(kk[7:0])) % 256;
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        for (int n = 0; n < 256; n++) s_ref[n] = 8'(s[n]);
        i = 0; j = 0;
        for (int n = 0; n < 256; n++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            ks_ref[n] = 8'(s[(s[i] + s[j]) % 256]);
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, " s_wren"}, s_wren, 0);
        check_eq({tag, " s_address"}, s_address, 0);
        check_eq({tag, " s_data"}, s_data, 0);
        check_eq({tag, " ct_data"}, ct_data, 0);
        check_eq({tag, " ct_valid"}, ct_valid, 0);
        check_eq({tag, " pt_ready"}, pt_ready, 0);
        check_eq({tag, " busy"}, busy, 0);
        check_eq({tag, " done"}, done, 0);
    endtask

    task automatic load_plaintext();
        logic [7:0] plain9 [9];
        plain9 = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
        for (int n = 0; n < 256; n++) pt_buf[n] = (n < 9) ? plain9[n] : 8'($urandom);
    endtask

    task automatic check_vec9(input string tag);
        logic [7:0] exp9 [9];
        exp9 = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        for (int n = 0; n < 9; n++) check_eq($sformatf("%s known_ct[%0d]", tag, n), ct_buf[n], exp9[n]);
    endtask

    // One full message: start, feed pt_buf, collect ct_buf, check against the reference.
    task automatic run_msg(input logic [23:0] key, input bit rnd_valid, input int stall_at,
                           input int stall_len, input int abort_at, input int poke_cyc,
                           input bit chk_ksa, input string tag);
        int cyc, pi, ci, last_rdy, stall_left, stall_bad, overlap;
        bit fin, aborted, took, gave;
        logic [7:0] held, cap;
        rc4_ref(key);
        @(posedge clk); #1;
        secret_key = key;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        secret_key = 24'($urandom);
        cyc = 1; pi = 0; ci = 0; last_rdy = -1; stall_left = stall_len; stall_bad = 0;
        overlap = 0; fin = 0; aborted = 0; held = 8'd0;
        first_rdy = -1; bad_gap = 0;
        check_eq({tag, " busy_after_start"}, busy, 1);
        while (!fin && cyc < LIMIT) begin
            if (pt_ready && ct_valid) overlap++;
            if (pt_ready) begin
                if (first_rdy < 0) first_rdy = cyc;
                else if (cyc - last_rdy != 10) bad_gap++;
                last_rdy = cyc;
            end
            if (chk_ksa && cyc == 1796) begin
                int bad;
                bad = 0;
                for (int n = 0; n < 256; n++) if (mem[n] !== s_ref[n]) bad++;
                check_eq({tag, " s_ram_after_ksa_diffs"}, bad, 0);
            end
            if (done) begin
                check_eq({tag, " busy_at_done"}, busy, 0);
                check_eq({tag, " bytes_before_done"}, ci, MSG_LEN);
                fin = 1;
            end else if (ct_valid && ci == abort_at) begin
                ct_ready = 1'b0;
                reset_n = 1'b0;
                @(posedge clk); #1;
                check_zero({tag, " mid_prga_reset"});
                reset_n = 1'b1;
                fin = 1;
                aborted = 1;
            end else begin
                start = (cyc == poke_cyc);
                if (cyc == poke_cyc) secret_key = ~key;
                pt_valid = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
                pt_data = pt_buf[pi];
                ct_ready = 1'b1;
                if (ct_valid && ci == stall_at && stall_left > 0) begin
                    if (stall_left == stall_len) held = ct_data;
                    else if (ct_data !== held) stall_bad++;
                    if (s_wren) stall_bad++;
                    ct_ready = 1'b0;
                    stall_left--;
                end else if (ct_valid && ci == stall_at && stall_len > 0 && ct_data !== held) begin
                    stall_bad++;
                end
                took = pt_ready && pt_valid;
                gave = ct_valid && ct_ready;
                cap = ct_data;
                @(posedge clk); #1;
                cyc++;
                if (took) pi++;
                if (gave) begin
                    ct_buf[ci] = cap;
                    ci++;
                end
            end
        end
        start = 1'b0;
        pt_valid = 1'b0;
        ct_ready = 1'b0;
        if (!fin) check_eq({tag, " finished_within_budget"}, 0, 1);
        check_eq({tag, " pt_ready_ct_valid_overlap"}, overlap, 0);
        if (stall_len > 0) check_eq({tag, " stall_hold_errors"}, stall_bad, 0);
        if (fin && !aborted) begin
            @(posedge clk); #1;
            check_eq({tag, " done_single_pulse"}, done, 0);
            for (int n = 0; n < MSG_LEN; n++)
                check_eq($sformatf("%s ct[%0d]", tag, n), ct_buf[n], pt_buf[n] ^ ks_ref[n]);
        end
    endtask

    initial begin
        logic [7:0] pt_orig [256];
        int diffs;

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset_n = 1'b1;

        // Known vector, no backpressure, cadence and KSA image.
        load_plaintext();
        run_msg(24'h4B6579, 1'b0, -1, 0, -1, -1, 1'b1, "vec");
        check_vec9("vec");
        // Cycle 1 is the first INIT cycle; P_GETPT follows INIT, KSA and 8 PRGA cycles.
        check_eq("vec first_pt_ready_cycle", first_rdy, 256 + 1536 + 9);
        check_eq("vec pt_ready_spacing_errors", bad_gap, 0);
        for (int n = 0; n < MSG_LEN; n++) keep_a[n] = ct_buf[n];

        // Same message with a 5-cycle sink stall on byte 3.
        run_msg(24'h4B6579, 1'b0, 3, 5, -1, -1, 1'b0, "stall");
        diffs = 0;
        for (int n = 0; n < MSG_LEN; n++) if (ct_buf[n] !== keep_a[n]) diffs++;
        check_eq("stall stream_vs_nostall_diffs", diffs, 0);

        // Round trip with random plaintext, random pt_valid gaps and a start poke mid-run.
        for (int n = 0; n < 256; n++) pt_buf[n] = 8'($urandom);
        for (int n = 0; n < 256; n++) pt_orig[n] = pt_buf[n];
        run_msg(24'h000002, 1'b1, -1, 0, -1, 1850, 1'b1, "rt_enc");
        for (int n = 0; n < MSG_LEN; n++) pt_buf[n] = ct_buf[n];
        run_msg(24'h000002, 1'b0, -1, 0, -1, 300, 1'b0, "rt_dec");
        diffs = 0;
        for (int n = 0; n < MSG_LEN; n++) if (ct_buf[n] !== pt_orig[n]) diffs++;
        check_eq("rt plaintext_recovered_diffs", diffs, 0);

        // Reset in the middle of the key schedule, then a clean run.
        @(posedge clk); #1;
        secret_key = 24'h123456;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (256 + 6 * 100) @(posedge clk);
        #1;
        check_eq("ksa_rst busy_before", busy, 1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check_zero("ksa_rst");
        reset_n = 1'b1;
        load_plaintext();
        run_msg(24'h4B6579, 1'b0, -1, 0, -1, -1, 1'b1, "after_ksa_rst");
        check_vec9("after_ksa_rst");

        // Reset while byte 4 waits in P_PUTCT, then a clean run.
        run_msg(24'h4B6579, 1'b0, -1, 0, 4, -1, 1'b0, "prga_abort");
        load_plaintext();
        run_msg(24'h4B6579, 1'b1, 7, 3, -1, -1, 1'b0, "after_prga_rst");
        check_vec9("after_prga_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
